register_file_write_port: RTL and testbench
===========================================

REGISTER_FILE_WRITE_PORT -- requirements
Module: register_file_write_port

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the bit width of one general-purpose register.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 SHALL have port wr_en, input, 1 bit: write request for the current cycle.
REQ-005 SHALL have port wr_word, input, 1 bit: 0 = byte write, 1 = register-pair write.
REQ-006 SHALL have port wr_addr, input, 5 bits: target register r0..r31 (pair low register when wr_word=1).
REQ-007 SHALL have port wr_data, input, 2*WIDTH bits: byte data in [WIDTH-1:0]; pair data low byte [WIDTH-1:0], high byte [2*WIDTH-1:WIDTH].
REQ-008 SHALL have port ptr_sel, input, 2 bits: 00 none, 01 X (r27:r26), 10 Y (r29:r28), 11 Z (r31:r30).
REQ-009 SHALL have port ptr_op, input, 1 bit: 0 = increment pointer, 1 = decrement pointer.
REQ-010 SHALL have port regs_out, output, 32*WIDTH bits: register n at [n*WIDTH +: WIDTH], feeding the read-side 32-way muxes.
REQ-011 SHALL have port wr_err, output, 1 bit: registered flag, high one cycle after a rejected request.

Function
REQ-012 Byte write: wr_en=1, wr_word=0 -> r[wr_addr] <= wr_data[WIDTH-1:0] on the next edge; visible on regs_out 1 cycle after the request.
REQ-013 Pair write, wr_addr even: r[wr_addr] <= low byte and r[wr_addr+1] <= high byte, atomically on the same edge.
REQ-014 Pair write, wr_addr odd: no register changes; wr_err=1 on the next cycle.
REQ-015 wr_err SHALL be 0 in every cycle not following a rejected request.
REQ-016 Pointer update (ptr_sel!=00): the 2*WIDTH-bit pair is incremented or decremented by 1 on the next edge, modulo 2^(2*WIDTH); 0xFFFF+1=0x0000, 0x0000-1=0xFFFF (WIDTH=8).
REQ-017 A carry or borrow SHALL propagate from the low byte to the high byte within the same cycle, e.g. X=0x00FF incremented -> 0x0100.
REQ-018 Write and pointer update on disjoint registers in the same cycle: both take effect on the same edge.
REQ-019 Write and pointer update overlapping at least one register of the pair: the write wins for each written byte; the pointer update SHALL be dropped entirely (no partial update); wr_err stays 0.
REQ-020 Registers not addressed in a cycle SHALL hold their value.
REQ-021 A rejected odd pair write SHALL NOT suppress a pointer update requested in the same cycle.

Reset
REQ-022 reset=1 at a rising edge: all 32 registers clear to 0 and wr_err clears to 0, overriding any write or pointer request in that cycle.
REQ-023 After reset deasserts, the first request is accepted on the first edge at which reset=0.

Configuration
REQ-024 REGFILE_PTR_UPDATE_EN defined: ptr_sel/ptr_op behave per REQ-016..REQ-019 and REQ-021.
REQ-025 REGFILE_PTR_UPDATE_EN undefined: ptr_sel/ptr_op ports remain but are ignored; no incrementer/decrementer logic is built; writes behave identically.

Structure
REQ-026 A shared package SHALL hold the register-count constant (32), the pointer base addresses (X=26, Y=28, Z=30) and the ptr_sel encodings.
REQ-027 One sub-module, register_pair_incdec (2*WIDTH-bit +/-1 with wrap), SHALL implement the pointer arithmetic and be instantiated once, behind REGFILE_PTR_UPDATE_EN.

Verification
REQ-028 Reset, then byte write r5=0xA7 -> regs_out r5=0xA7 next cycle; all other registers 0x00.
REQ-029 Pair write addr 24, data 0x1234 -> r24=0x34, r25=0x12; pair write addr 25 -> no change, wr_err=1 for exactly one cycle.
REQ-030 Z=0xFFFF, increment -> Z=0x0000; X=0x0100, decrement -> X=0x00FF.
REQ-031 Same cycle: byte write r26=0x55 and X increment -> r26=0x55, r27 unchanged; byte write r3 and Y increment -> both applied.
REQ-032 Reset asserted during a pair write and Z update -> all registers 0x00 and wr_err=0 next cycle.
REQ-033 Build without REGFILE_PTR_UPDATE_EN: Y increment request -> r28/r29 unchanged; byte and pair writes still pass REQ-028/REQ-029.

Source files
------------

// File: rtl/register_file_write_port_pkg.sv
// Shared constants for the register file write port.
// Holds the pointer-pair base addresses and the ptr_sel encodings.
package register_file_write_port_pkg;

   localparam int NUM_REGS = 32;

   localparam logic [4:0] PTR_X_BASE = 5'd26;
   localparam logic [4:0] PTR_Y_BASE = 5'd28;
   localparam logic [4:0] PTR_Z_BASE = 5'd30;

   typedef enum logic [1:0] {
      PTR_NONE = 2'b00,
      PTR_X    = 2'b01,
      PTR_Y    = 2'b10,
      PTR_Z    = 2'b11
   } ptr_sel_e;

   function automatic logic [4:0] ptr_base(input logic [1:0] sel);
      logic [4:0] b;
      case (sel)
         PTR_X:   b = PTR_X_BASE;
         PTR_Y:   b = PTR_Y_BASE;
         default: b = PTR_Z_BASE;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/register_file_write_port_incdec.sv
// register_pair_incdec: W-bit +/-1 with natural wrap-around.
// The carry/borrow runs across the full pair in one cycle.
module register_pair_incdec #(
   parameter int W = 16
) (
   input  logic [W-1:0] val,
   input  logic         dec,
   output logic [W-1:0] res
);

   localparam logic [W-1:0] ONE = W'(1);

   assign res = dec ? (val - ONE) : (val + ONE);

endmodule

// File: rtl/register_file_write_port.sv
// 32-entry register file write port with byte/pair writes and
// optional X/Y/Z pointer inc/dec (macro REGFILE_PTR_UPDATE_EN).
module register_file_write_port
   import register_file_write_port_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic                  wr_word,
   input  logic [4:0]            wr_addr,
   input  logic [2*WIDTH-1:0]    wr_data,
   input  logic [1:0]            ptr_sel,
   input  logic                  ptr_op,
   output logic [32*WIDTH-1:0]   regs_out,
   output logic                  wr_err
);

   logic [NUM_REGS-1:0][WIDTH-1:0] regs_q, regs_d;
   logic                           err_q, err_d;
   logic                           wr_byte;
   logic                           wr_pair;
   logic                           wr_active;
   logic [4:0]                     wr_addr_hi;

   assign wr_byte    = wr_en & ~wr_word;
   assign wr_pair    = wr_en & wr_word & ~wr_addr[0];
   assign wr_active  = wr_byte | wr_pair;
   assign wr_addr_hi = {wr_addr[4:1], 1'b1};

`ifdef REGFILE_PTR_UPDATE_EN
   logic [4:0]         pbase;
   logic [4:0]         pbase_hi;
   logic [2*WIDTH-1:0] pair_val;
   logic [2*WIDTH-1:0] pair_nxt;
   logic               ptr_go;

   assign pbase    = ptr_base(ptr_sel);
   assign pbase_hi = {pbase[4:1], 1'b1};
   assign pair_val = {regs_q[pbase_hi], regs_q[pbase]};

   // Pairs are aligned, so any accepted write into the pair
   // shares the upper address bits and cancels the update.
   assign ptr_go = (ptr_sel != PTR_NONE) &&
                   !(wr_active && (wr_addr[4:1] == pbase[4:1]));

   register_pair_incdec #(
      .W (2*WIDTH)
   ) u_incdec (
      .val (pair_val),
      .dec (ptr_op),
      .res (pair_nxt)
   );
`else
   logic unused_ptr;
   assign unused_ptr = ^{ptr_sel, ptr_op};
`endif

   always_comb begin
      regs_d = regs_q;
      err_d  = wr_en & wr_word & wr_addr[0];
`ifdef REGFILE_PTR_UPDATE_EN
      if (ptr_go) begin
         regs_d[pbase]    = pair_nxt[WIDTH-1:0];
         regs_d[pbase_hi] = pair_nxt[2*WIDTH-1:WIDTH];
      end
`endif
      if (wr_byte) begin
         regs_d[wr_addr] = wr_data[WIDTH-1:0];
      end
      if (wr_pair) begin
         regs_d[wr_addr]    = wr_data[WIDTH-1:0];
         regs_d[wr_addr_hi] = wr_data[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q <= '0;
         err_q  <= 1'b0;
      end else begin
         regs_q <= regs_d;
         err_q  <= err_d;
      end
   end

   assign regs_out = regs_q;
   assign wr_err   = err_q;

endmodule

// File: tb/tb_register_file_write_port.sv
// Directed scoreboard bench for register_file_write_port.
// Expectations follow REGFILE_PTR_UPDATE_EN as compiled.
module tb_register_file_write_port;

   localparam int W = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            wr_en;
   logic            wr_word;
   logic [4:0]      wr_addr;
   logic [2*W-1:0]  wr_data;
   logic [1:0]      ptr_sel;
   logic            ptr_op;
   logic [32*W-1:0] regs_out;
   logic            wr_err;

   register_file_write_port #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_word  (wr_word),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .ptr_sel  (ptr_sel),
      .ptr_op   (ptr_op),
      .regs_out (regs_out),
      .wr_err   (wr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [32*W-1:0] regs;
      logic            err;
      string           tag;
   } exp_t;

   exp_t      sb[$];
   logic [W-1:0] mdl [32];
   int        checks = 0;
   int        errors = 0;

`ifdef REGFILE_PTR_UPDATE_EN
   localparam bit PTR_EN = 1'b1;
`else
   localparam bit PTR_EN = 1'b0;
`endif

   task automatic chk8(input string tag, input int r, input logic [W-1:0] exp);
      logic [W-1:0] got;
      got = regs_out[r*W +: W];
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s r%0d got %h exp %h", tag, r, got, exp);
      end
   endtask

   task automatic step(input string tag, input logic rst, input logic en,
                       input logic word, input logic [4:0] addr,
                       input logic [2*W-1:0] data, input logic [1:0] psel,
                       input logic pop);
      logic [W-1:0]    nxt [32];
      bit              hit [32];
      logic [2*W-1:0]  v;
      exp_t            e;
      int              b;
      exp_t            o;
      reset = rst; wr_en = en; wr_word = word; wr_addr = addr;
      wr_data = data; ptr_sel = psel; ptr_op = pop;
      for (int i = 0; i < 32; i++) begin
         nxt[i] = mdl[i];
         hit[i] = 0;
      end
      e.err = 1'b0;
      if (rst) begin
         for (int i = 0; i < 32; i++) nxt[i] = '0;
      end else begin
         if (en && word && addr[0]) e.err = 1'b1;
         if (en && !word) begin
            nxt[addr] = data[W-1:0];
            hit[addr] = 1;
         end
         if (en && word && !addr[0]) begin
            nxt[addr]     = data[W-1:0];
            nxt[addr + 1] = data[2*W-1:W];
            hit[addr]     = 1;
            hit[addr + 1] = 1;
         end
         if (PTR_EN && psel != 2'b00) begin
            b = 24 + 2 * int'(psel);
            if (!hit[b] && !hit[b+1]) begin
               v = {mdl[b+1], mdl[b]};
               v = pop ? v - 1'b1 : v + 1'b1;
               nxt[b]   = v[W-1:0];
               nxt[b+1] = v[2*W-1:W];
            end
         end
      end
      for (int i = 0; i < 32; i++) begin
         mdl[i] = nxt[i];
         e.regs[i*W +: W] = nxt[i];
      end
      e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      checks++;
      assert (sb.size() != 0) else begin
         errors++;
         $error("FAIL %s scoreboard empty got 0 exp 1", tag);
      end
      if (sb.size() != 0) begin
         o = sb.pop_front();
         checks++;
         assert (regs_out === o.regs) else begin
            errors++;
            $error("FAIL %s regs got %h exp %h", o.tag, regs_out, o.regs);
         end
         checks++;
         assert (wr_err === o.err) else begin
            errors++;
            $error("FAIL %s wr_err got %b exp %b", o.tag, wr_err, o.err);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      reset = 1; wr_en = 0; wr_word = 0; wr_addr = 0;
      wr_data = 0; ptr_sel = 0; ptr_op = 0;

      step("reset",    1, 1, 1, 5'd30, 16'hBEEF, 2'b11, 0);
      chk8("rst_r0", 0, 8'h00);
      step("byte_r5",  0, 1, 0, 5'd5,  16'h00A7, 2'b00, 0);
      chk8("byte_r5", 5, 8'hA7);
      chk8("byte_r4", 4, 8'h00);
      step("pair_24",  0, 1, 1, 5'd24, 16'h1234, 2'b00, 0);
      chk8("pair_lo", 24, 8'h34);
      chk8("pair_hi", 25, 8'h12);
      step("pair_odd", 0, 1, 1, 5'd25, 16'hFFFF, 2'b00, 0);
      chk8("odd_r25", 25, 8'h12);
      step("idle",     0, 0, 0, 5'd0,  16'h0000, 2'b00, 0);
      step("z_set",    0, 1, 1, 5'd30, 16'hFFFF, 2'b00, 0);
      step("z_inc",    0, 0, 0, 5'd0,  16'h0000, 2'b11, 0);
      chk8("z_wrap", 31, PTR_EN ? 8'h00 : 8'hFF);
      step("x_set",    0, 1, 1, 5'd26, 16'h0100, 2'b00, 0);
      step("x_dec",    0, 0, 0, 5'd0,  16'h0000, 2'b01, 1);
      chk8("x_borrow", 27, PTR_EN ? 8'h00 : 8'h01);
      step("x_inc",    0, 0, 0, 5'd0,  16'h0000, 2'b01, 0);
      chk8("x_carry", 27, 8'h01);
      step("ovl_x",    0, 1, 0, 5'd26, 16'h0055, 2'b01, 0);
      chk8("ovl_lo", 26, 8'h55);
      chk8("ovl_hi", 27, 8'h01);
      step("dis_y",    0, 1, 0, 5'd3,  16'h003C, 2'b10, 0);
      chk8("dis_r3", 3, 8'h3C);
      chk8("dis_y", 28, PTR_EN ? 8'h01 : 8'h00);
      step("odd_ydec", 0, 1, 1, 5'd27, 16'hAAAA, 2'b10, 1);
      chk8("odd_y", 28, 8'h00);
      step("ovl_pair", 0, 1, 1, 5'd28, 16'hABCD, 2'b10, 0);
      step("ovl_hi_y", 0, 1, 0, 5'd29, 16'h0077, 2'b10, 0);
      chk8("ovl_hi_lo", 28, 8'hCD);
      for (int i = 0; i < 24; i++) begin
         step("rand", 0, 1'($urandom), 1'($urandom), 5'($urandom),
              16'($urandom), 2'($urandom), 1'($urandom));
      end
      step("rst_busy", 1, 1, 1, 5'd30, 16'h5A5A, 2'b11, 0);
      chk8("rst_r31", 31, 8'h00);
      step("post_rst", 0, 1, 0, 5'd7,  16'h0099, 2'b00, 0);
      chk8("post_r7", 7, 8'h99);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
